shift_add_mult4_ctrl: RTL and testbench

- Sequential unsigned N x N shift-and-add multiplier controller.
- Performs one add-and-shift step per clock and produces a 2N-bit product.
- Owns no adder: drives the operands of the team's external 4-bit ripple-carry adder (ripple_carry_adder4bit) and consumes its sum/cout on the same cycle.
- Sits directly upstream and downstream of that adder, closing the loop through a start/busy/done handshake.

---
 rtl/shift_add_mult4_ctrl.sv | 83 ++++++++
 tb/tb_shift_add_mult4_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult4_ctrl.sv
// shift_add_mult4_ctrl: sequential N x N shift-and-add multiplier controller driving an external N-bit adder.
// One add-and-shift per clock; the adder sum/cout is consumed combinationally in the same cycle.
module shift_add_mult4_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [N-1:0]   add_a,
    output logic [N-1:0]   add_b,
    output logic           add_cin,
    input  logic [N-1:0]   add_sum,
    input  logic           add_cout,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = $clog2(N);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [N-1:0]   acc_q, acc_d, mreg_q, mreg_d, qreg_q, qreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] product_q, product_d;

    assign busy    = state_q == CALC;
    assign done    = state_q == DONE;
    assign add_a   = busy ? acc_q : '0;
    assign add_b   = (busy && qreg_q[0]) ? mreg_q : '0;
    assign add_cin = 1'b0;
    assign product = product_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mreg_d    = mreg_q;
        qreg_d    = qreg_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: if (start) begin
                mreg_d  = multiplicand;
                qreg_d  = multiplier;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                // carry becomes the new MSB so the shifted partial product never overflows
                acc_d  = {add_cout, add_sum[N-1:1]};
                qreg_d = {add_sum[0], qreg_q[N-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(N-1)) begin
                    product_d = {add_cout, add_sum[N-1:1], add_sum[0], qreg_q[N-1:1]};
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mreg_q    <= '0;
            qreg_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mreg_q    <= mreg_d;
            qreg_q    <= qreg_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end
endmodule

// File: tb/tb_shift_add_mult4_ctrl.sv
// tb_shift_add_mult4_ctrl: closes the loop with a 4-bit ripple adder and checks against a timing/arithmetic model.
module tb_shift_add_mult4_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0] multiplicand = '0, multiplier = '0;
    logic [3:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout, busy, done;
    logic [7:0] product;

    always #5 clk = ~clk;

    shift_add_mult4_ctrl #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy), .done(done), .product(product)
    );

    always_comb begin
        logic c;
        c = add_cin;
        add_sum = '0;
        for (int i = 0; i < 4; i++) begin
            add_sum[i] = add_a[i] ^ add_b[i] ^ c;
            c = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
        end
        add_cout = c;
    end

    int checks = 0, errors = 0;
    int dut_dones = 0, exp_dones = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: an op accepted at edge t0 is busy after edges t0..t0+3, done after t0+4, idle from t0+5
    int         edge_n = 0, t0 = 0;
    bit         active = 1'b0, chk_en = 1'b0;
    logic [7:0] exp_prod = '0, pend = '0;

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (!rst_n) begin
            active   <= 1'b0;
            exp_prod <= '0;
        end else begin
            if (active && edge_n - t0 == 4) begin
                exp_prod  <= pend;
                exp_dones <= exp_dones + 1;
            end
            if (start && (!active || edge_n - t0 >= 6)) begin
                active <= 1'b1;
                t0     <= edge_n;
                pend   <= 8'(multiplicand * multiplier);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            automatic int rel = edge_n - 1 - t0;
            chk("busy", 32'(busy), 32'(active && rel >= 0 && rel <= 3));
            chk("done", 32'(done), 32'(active && rel == 4));
            chk("product", 32'(product), 32'(exp_prod));
            chk("add_cin", 32'(add_cin), 32'd0);
            if (!busy) chk("idle_operands", 32'({add_a, add_b}), 32'd0);
            if (done) dut_dones++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string nm, input int lat);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk({nm, "_done_seen"}, 32'(done), 32'd1);
        chk({nm, "_latency"}, 32'(n), 32'(lat));
    endtask

    task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp, input string nm);
        start = 1'b1;
        multiplicand = m;
        multiplier = q;
        tick();
        start = 1'b0;
        multiplicand = 4'($urandom);
        multiplier = 4'($urandom);
        wait_done(nm, 4);
        chk({nm, "_product"}, 32'(product), 32'(exp));
        tick();
    endtask

    initial begin
        int base;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_product", 32'(product), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        run_op(4'd3, 4'd5, 8'h0F, "m3q5");
        run_op(4'd15, 4'd15, 8'hE1, "m15q15");
        run_op(4'd0, 4'd9, 8'h00, "m0q9");
        run_op(4'd9, 4'd0, 8'h00, "m9q0");
        // start pulsed mid-calculation must be dropped
        base = dut_dones;
        start = 1'b1; multiplicand = 4'd7; multiplier = 4'd6;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; multiplicand = 4'd2; multiplier = 4'd2;
        tick();
        start = 1'b0;
        wait_done("ignored_start", 2);
        chk("ignored_start_product", 32'(product), 32'h2A);
        repeat (8) tick();
        chk("ignored_start_dones", 32'(dut_dones - base), 32'd1);
        // reset during the 2nd calculation edge aborts without publishing
        base = dut_dones;
        start = 1'b1; multiplicand = 4'd15; multiplier = 4'd15;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_product", 32'(product), 32'h00);
        repeat (8) tick();
        chk("abort_dones", 32'(dut_dones - base), 32'd0);
        run_op(4'd2, 4'd3, 8'h06, "m2q3");
        // start held high: exhaustive back-to-back ops, one every 6 cycles
        base = dut_dones;
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            multiplicand = 4'(i >> 4);
            multiplier = 4'(i);
            tick();
            for (int k = 1; k < 6; k++) begin
                multiplicand = 4'($urandom);
                multiplier = 4'($urandom);
                tick();
                if (k == 4) begin
                    chk("ex_done", 32'(done), 32'd1);
                    chk("ex_product", 32'(product), 32'((i >> 4) * (i & 15)));
                end
            end
        end
        start = 1'b0;
        tick();
        chk("ex_dones", 32'(dut_dones - base), 32'd256);
        // random traffic with occasional resets, checked by the model each cycle
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            multiplicand = 4'($urandom);
            multiplier = 4'($urandom);
            rst_n = ($urandom_range(0, 60) != 0);
            tick();
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (10) tick();
        chk("total_dones", 32'(dut_dones), 32'(exp_dones));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
